// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: result-source codes,
// forwarding selects, shadow pipeline records and the forwarding rule.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_MEM  = 2'b01;
  localparam logic [1:0] RESULT_JUMP = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_MEM_WAIT,
    HZ_EX_BUSY,
    HZ_REDIRECT,
    HZ_LOAD_USE
  } hz_case_t;

  // Producer record kept for the E and M stages.
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    reg_addr_t  rd;
    logic [1:0] resultsrc;
  } hz_stage_t;

  // Write-back only needs to know which register it is about to write.
  typedef struct packed {
    logic      valid;
    logic      regwrite;
    reg_addr_t rd;
  } hz_wb_t;

  function automatic fwd_sel_t fwd_select(input reg_addr_t rs, input hz_stage_t m, input hz_wb_t w);
    if (rs == '0) return FWD_REG;
    if (m.valid && m.regwrite && (m.rd == rs) && (m.resultsrc == RESULT_ALU)) return FWD_MEM;
    if (w.valid && w.regwrite && (w.rd == rs)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadows the E/M/W destination registers and
// drives stall, flush and forwarding selects for the pipeline registers.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      RegWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      PCSrcE,
  input  logic                      ex_busy,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  hz_stage_t e_q, e_d, m_q, m_d;
  hz_wb_t    w_q, w_d;
  reg_addr_t e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
  reg_addr_t rs1_d_in, rs2_d_in;
  hz_case_t  hz_case;
  logic      mem_wait, use_hz;

  assign rs1_d_in = reg_addr_t'(Rs1D);
  assign rs2_d_in = reg_addr_t'(Rs2D);

  always_comb begin
    mem_wait = m_q.valid & dmem_req & ~dmem_ready;
    use_hz   = e_q.valid & e_q.regwrite & (e_q.rd != '0) & (e_q.resultsrc != RESULT_ALU)
             & ((e_q.rd == rs1_d_in) | (e_q.rd == rs2_d_in));
    hz_case  = HZ_NONE;
    if (reset) begin
      if (mem_wait)     hz_case = HZ_MEM_WAIT;
      else if (ex_busy) hz_case = HZ_EX_BUSY;
      else if (PCSrcE)  hz_case = HZ_REDIRECT;
      else if (use_hz)  hz_case = HZ_LOAD_USE;
    end
  end

  always_comb begin
    {StallF, StallD, StallE, StallM} = '0;
    {FlushD, FlushE, FlushM, FlushW} = '0;
    case (hz_case)
      HZ_MEM_WAIT: begin
        {StallF, StallD, StallE, StallM} = '1;
        FlushW = 1'b1;
      end
      HZ_EX_BUSY: begin
        {StallF, StallD, StallE} = '1;
        FlushM = 1'b1;
      end
      HZ_REDIRECT: {FlushD, FlushE} = '1;
      HZ_LOAD_USE: begin
        {StallF, StallD} = '1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (reset) begin
      ForwardAE = fwd_select(e_rs1_q, m_q, w_q);
      ForwardBE = fwd_select(e_rs2_q, m_q, w_q);
    end
  end

  // Shadow advances exactly as the real pipeline registers do; a bubble is an all-zero record.
  always_comb begin
    e_d     = e_q;
    e_rs1_d = e_rs1_q;
    e_rs2_d = e_rs2_q;
    m_d     = m_q;
    w_d     = FlushW ? '0 : '{valid: m_q.valid, regwrite: m_q.regwrite, rd: m_q.rd};
    if (!StallM) m_d = FlushM ? '0 : e_q;
    if (!StallE) begin
      if (FlushE) begin
        e_d     = '0;
        e_rs1_d = '0;
        e_rs2_d = '0;
      end else begin
        e_d     = '{valid: 1'b1, regwrite: RegWriteD, rd: reg_addr_t'(RdD), resultsrc: ResultSrcD};
        e_rs1_d = rs1_d_in;
        e_rs2_d = rs2_d_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q     <= '0;
      e_rs1_q <= '0;
      e_rs2_q <= '0;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      e_q     <= e_d;
      e_rs1_q <= e_rs1_d;
      e_rs2_q <= e_rs2_d;
      m_q     <= m_d;
      w_q     <= w_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallD),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hz_case == HZ_REDIRECT),
    .count (flush_cnt)
  );

  // A non-ALU producer in M matching an E operand means a load-use stall was missed.
  a_no_late_mem_fwd: assert property (@(posedge clk) disable iff (!reset)
    !(m_q.valid && m_q.regwrite && (m_q.resultsrc != RESULT_ALU) &&
      (((e_rs1_q != '0) && (m_q.rd == e_rs1_q)) || ((e_rs2_q != '0) && (m_q.rd == e_rs2_q)))));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios with literal expectations,
// then randomized traffic, all cross-checked each cycle against an instruction-level model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, RdD;
  logic          RegWriteD;
  logic [1:0]    ResultSrcD;
  logic          PCSrcE, ex_busy, dmem_req, dmem_ready;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushM, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .PCSrcE(PCSrcE), .ex_busy(ex_busy), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Instructions in flight behind decode: [0]=E, [1]=M, [2]=W; a bubble is all zero.
  typedef struct packed {
    bit       v;
    bit       rw;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [1:0] src;
  } ins_t;

  ins_t pipe [3];
  int   m_stall = 0;
  int   m_flush = 0;

  // Newest available producer of rs: an ALU result in M beats anything in W.
  function automatic logic [1:0] exp_fwd(input bit [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == rs && pipe[1].src == RESULT_ALU) return 2'b10;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin : compare
    logic [3:0] st;
    logic [3:0] fl;
    logic [1:0] fa, fb;
    logic       wait_m, use_h, redirect;
    ins_t       dec;
    st = '0; fl = '0; fa = '0; fb = '0;
    wait_m = 1'b0; use_h = 1'b0; redirect = 1'b0;
    if (reset) begin
      wait_m = pipe[1].v && dmem_req && !dmem_ready;
      use_h  = pipe[0].v && pipe[0].rw && pipe[0].rd != 5'd0 && pipe[0].src != RESULT_ALU
               && (pipe[0].rd == Rs1D || pipe[0].rd == Rs2D);
      if (wait_m)       begin st = 4'b1111; fl = 4'b1000; end
      else if (ex_busy) begin st = 4'b0111; fl = 4'b0100; end
      else if (PCSrcE)  begin fl = 4'b0011; redirect = 1'b1; end
      else if (use_h)   begin st = 4'b0011; fl = 4'b0010; end
      fa = exp_fwd(pipe[0].rs1);
      fb = exp_fwd(pipe[0].rs2);
    end
    check("stall{M,E,D,F}", 32'({StallM, StallE, StallD, StallF}), 32'(st));
    check("flush{W,M,E,D}", 32'({FlushW, FlushM, FlushE, FlushD}), 32'(fl));
    check("ForwardAE", 32'(ForwardAE), 32'(fa));
    check("ForwardBE", 32'(ForwardBE), 32'(fb));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (!reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (st[1] && m_stall < CMAX) m_stall++;
      if (redirect && m_flush < CMAX) m_flush++;
      if (fl[3]) pipe[2] = '0;
      else       pipe[2] = pipe[1];
      if (!st[3]) begin
        if (fl[2]) pipe[1] = '0;
        else       pipe[1] = pipe[0];
      end
      if (!st[2]) begin
        dec = '{v: 1'b1, rw: RegWriteD, rd: RdD, rs1: Rs1D, rs2: Rs2D, src: ResultSrcD};
        if (fl[1]) pipe[0] = '0;
        else       pipe[0] = dec;
      end
    end
  end

  task automatic issue(input int rs1, input int rs2, input int rd, input bit rw, input logic [1:0] src,
                       input bit pc = 1'b0, input bit busy = 1'b0, input bit req = 1'b0,
                       input bit rdy = 1'b1, input bit rst = 1'b1);
    @(posedge clk);
    #1;
    reset      = rst;
    Rs1D       = 5'(rs1);
    Rs2D       = 5'(rs2);
    RdD        = 5'(rd);
    RegWriteD  = rw;
    ResultSrcD = src;
    PCSrcE     = pc;
    ex_busy    = busy;
    dmem_req   = req;
    dmem_ready = rdy;
  endtask

  task automatic nop(input bit busy = 1'b0, input bit rst = 1'b1);
    issue(0, 0, 0, 1'b0, RESULT_ALU, 1'b0, busy, 1'b0, 1'b1, rst);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; ResultSrcD = RESULT_ALU;
    PCSrcE = 1'b0; ex_busy = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;

    nop(1'b0, 1'b0);
    nop(1'b1, 1'b0);
    settle();
    check("reset stalls/flushes", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}), 32'd0);
    check("reset forwards", 32'({ForwardAE, ForwardBE}), 32'd0);

    // add x5 -> add x6,x5,x1 : M-stage forward, no stall
    issue(1, 2, 5, 1'b1, RESULT_ALU);
    settle();
    check("post-reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("post-reset flush_cnt", 32'(flush_cnt), 32'd0);
    issue(5, 1, 6, 1'b1, RESULT_ALU);
    settle();
    check("alu-alu no stall", 32'(StallD), 32'd0);
    nop();
    settle();
    check("alu-alu ForwardAE", 32'(ForwardAE), 32'd2);
    check("alu-alu ForwardBE", 32'(ForwardBE), 32'd0);

    // lw x5 -> add x6,x5,x5 : one bubble, then W-stage forward on both operands
    issue(2, 0, 5, 1'b1, RESULT_MEM);
    issue(5, 5, 6, 1'b1, RESULT_ALU);
    settle();
    check("load-use {F,D,FlushE,E}", 32'({StallF, StallD, FlushE, StallE}), 32'b1110);
    check("load-use stall_cnt before", 32'(stall_cnt), 32'd0);
    issue(5, 5, 6, 1'b1, RESULT_ALU);
    settle();
    check("load-use released", 32'(StallD), 32'd0);
    check("load-use stall_cnt after", 32'(stall_cnt), 32'd1);
    nop();
    settle();
    check("load-use fwd A/B", 32'({ForwardAE, ForwardBE}), 32'b0101);

    // jal x1 -> add x2,x1,x0 : jump result is treated as a load-use hazard
    issue(0, 0, 1, 1'b1, RESULT_JUMP);
    issue(1, 0, 2, 1'b1, RESULT_ALU);
    settle();
    check("jal-use {D,FlushE}", 32'({StallD, FlushE}), 32'b11);
    issue(1, 0, 2, 1'b1, RESULT_ALU);
    settle();
    check("jal-use stall_cnt", 32'(stall_cnt), 32'd2);
    nop();
    settle();
    check("jal-use fwd A/B", 32'({ForwardAE, ForwardBE}), 32'b0100);

    // redirect in the same cycle as a load-use hazard: redirect wins
    issue(3, 0, 7, 1'b1, RESULT_MEM);
    issue(7, 7, 8, 1'b1, RESULT_ALU, 1'b1);
    settle();
    check("redirect {FlushD,FlushE,StallF,StallD}", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);
    check("redirect flush_cnt before", 32'(flush_cnt), 32'd0);
    nop();
    settle();
    check("redirect flush_cnt after", 32'(flush_cnt), 32'd1);
    check("redirect stall_cnt unchanged", 32'(stall_cnt), 32'd2);

    // sw held in M for three cycles by dmem_ready low, then add x10 -> add x11,x10 resumes
    issue(2, 9, 0, 1'b0, RESULT_ALU);
    issue(1, 2, 10, 1'b1, RESULT_ALU);
    for (int i = 0; i < 3; i++) begin
      issue(10, 0, 11, 1'b1, RESULT_ALU, 1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      check("mem_wait {F,D,E,M,FlushW}", 32'({StallF, StallD, StallE, StallM, FlushW}), 32'b11111);
      check("mem_wait other flushes", 32'({FlushD, FlushE, FlushM}), 32'd0);
    end
    issue(10, 0, 11, 1'b1, RESULT_ALU, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    check("mem_wait released", 32'({StallD, StallM}), 32'd0);
    check("mem_wait stall_cnt", 32'(stall_cnt), 32'd5);
    nop();
    settle();
    check("mem_wait resumed ForwardAE", 32'(ForwardAE), 32'd2);

    // reset dropped in the middle of an ex_busy stall
    nop(1'b1);
    settle();
    check("ex_busy {F,D,E,FlushM}", 32'({StallF, StallD, StallE, FlushM}), 32'b1111);
    nop(1'b1, 1'b0);
    settle();
    check("reset mid-busy outputs", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}), 32'd0);
    nop();
    settle();
    check("after reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("after reset flush_cnt", 32'(flush_cnt), 32'd0);
    check("after reset hazard-free", 32'({StallD, FlushE, ForwardAE, ForwardBE}), 32'd0);

    // writes to x0 never forward and never cause a load-use stall
    issue(1, 2, 0, 1'b1, RESULT_ALU);
    issue(0, 0, 3, 1'b1, RESULT_ALU);
    nop();
    settle();
    check("x0 no forward", 32'({ForwardAE, ForwardBE}), 32'd0);
    issue(1, 0, 0, 1'b1, RESULT_MEM);
    issue(0, 0, 4, 1'b1, RESULT_ALU);
    settle();
    check("x0 load no stall", 32'(StallD), 32'd0);

    // randomized traffic over a small register window to provoke collisions
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      reset      = ($urandom_range(0, 399) != 0);
      Rs1D       = 5'($urandom_range(0, 7));
      Rs2D       = 5'($urandom_range(0, 7));
      RdD        = 5'($urandom_range(0, 7));
      RegWriteD  = ($urandom_range(0, 3) != 0);
      ResultSrcD = 2'($urandom_range(0, 2));
      PCSrcE     = ($urandom_range(0, 9) == 0);
      ex_busy    = ($urandom_range(0, 7) == 0);
      dmem_req   = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 1) == 0);
    end

    settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
